// File: rtl/ctr12_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ctr12_pkg
// Brief   : Shared types and constants for the ctr12_window frame counter.
// Revision: 1.0
// ============================================================================
package ctr12_pkg;

  localparam int unsigned W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Register-select codes on ld_sel; code 3 is silently ignored.
  localparam logic [1:0] SEL_PERIOD = 2'd0;
  localparam logic [1:0] SEL_START  = 2'd1;
  localparam logic [1:0] SEL_END    = 2'd2;

  // Bit positions inside the pending-valid vector.
  localparam int unsigned IDX_PERIOD = 0;
  localparam int unsigned IDX_START  = 1;
  localparam int unsigned IDX_END    = 2;

  function automatic logic sel_valid(input logic [1:0] sel);
    return (sel != 2'd3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctr12_window_cmp.sv
`default_nettype none
// ============================================================================
// Module  : ctr12_cmp
// Brief   : Combinational W-bit unsigned magnitude compare (a vs b).
// Revision: 1.0
// ============================================================================
module ctr12_cmp
  import ctr12_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         agb,
  output logic         aeb,
  output logic         alb
);

  assign agb = (a > b);
  assign aeb = (a == b);
  assign alb = (a < b);

endmodule
`default_nettype wire

// File: rtl/ctr12_window.sv
`default_nettype none
// ============================================================================
// Module  : ctr12_window
// Brief   : Programmable frame counter (0..PERIOD) with double-buffered
//           window decode [START, END) and start/end match events.
//           Define CTR12_IRQ_EN to build the sticky frame interrupt.
// Revision: 1.0
// ============================================================================
module ctr12_window
  import ctr12_pkg::*;
#(
  parameter int unsigned     W          = W_DEFAULT,
  parameter logic [W-1:0]    RST_PERIOD = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         resetl,
  input  logic         en,
  input  logic         ld,
  input  logic [1:0]   ld_sel,
  input  logic [W-1:0] ld_data,
  output logic         ld_ack,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         win,
  output logic         match_st,
  output logic         match_end,
  output logic         irq,
  input  logic         irq_ack
);

  localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;

  logic [W-1:0] r_period;
  logic [W-1:0] r_start;
  logic [W-1:0] r_end;
  logic [W-1:0] r_pend_period;
  logic [W-1:0] r_pend_start;
  logic [W-1:0] r_pend_end;
  logic [2:0]   r_pend_vld;
  logic [2:0]   w_pend_vld_nxt;

  logic [W-1:0] w_period_nxt;
  logic [W-1:0] w_start_nxt;
  logic [W-1:0] w_end_nxt;

  logic         r_wrap;
  logic         r_win;
  logic         r_match_st;
  logic         r_match_end;
  logic         r_ld_ack;

  logic         w_running;
  logic         w_term;
  logic         w_xfer;
  logic         w_ld_ok;
  logic         w_active_nxt;

  logic         w_cnt_eq_period;
  logic         w_nxt_eq_start;
  logic         w_nxt_lt_start;
  logic         w_nxt_eq_end;
  logic         w_nxt_lt_end;
  logic         w_unused_p_gt;
  logic         w_unused_p_lt;
  logic         w_unused_s_gt;
  logic         w_unused_e_gt;

  // --------------------------------------------------------------------------
  // Compares: terminal count uses the current count; the window decode uses
  // the next count against the next active registers so outputs line up with
  // the count they describe, including across a register transfer.
  // --------------------------------------------------------------------------
  ctr12_cmp #(.W(W)) u_cmp_period (
    .a   (r_count),
    .b   (r_period),
    .agb (w_unused_p_gt),
    .aeb (w_cnt_eq_period),
    .alb (w_unused_p_lt)
  );

  ctr12_cmp #(.W(W)) u_cmp_start (
    .a   (w_count_nxt),
    .b   (w_start_nxt),
    .agb (w_unused_s_gt),
    .aeb (w_nxt_eq_start),
    .alb (w_nxt_lt_start)
  );

  ctr12_cmp #(.W(W)) u_cmp_end (
    .a   (w_count_nxt),
    .b   (w_end_nxt),
    .agb (w_unused_e_gt),
    .aeb (w_nxt_eq_end),
    .alb (w_nxt_lt_end)
  );

  assign w_running    = (r_state != IDLE);
  assign w_term       = w_running && w_cnt_eq_period;
  assign w_xfer       = !w_running || w_term;
  assign w_ld_ok      = ld && sel_valid(ld_sel);
  assign w_active_nxt = (w_state_nxt != IDLE);

  // --------------------------------------------------------------------------
  // FSM next-state and counter
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        if (en) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_count_nxt = w_term ? '0 : (r_count + c_one);
        if (!en) begin
          w_state_nxt = w_term ? IDLE : STOP;
        end
      end
      STOP: begin
        w_count_nxt = w_term ? '0 : (r_count + c_one);
        if (en) begin
          w_state_nxt = RUN;
        end else if (w_term) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Double buffering: a write landing in the transfer cycle keeps its flag and
  // waits for the following boundary.
  // --------------------------------------------------------------------------
  assign w_period_nxt = (w_xfer && r_pend_vld[IDX_PERIOD]) ? r_pend_period : r_period;
  assign w_start_nxt  = (w_xfer && r_pend_vld[IDX_START])  ? r_pend_start  : r_start;
  assign w_end_nxt    = (w_xfer && r_pend_vld[IDX_END])    ? r_pend_end    : r_end;

  always_comb begin
    w_pend_vld_nxt = w_xfer ? 3'b000 : r_pend_vld;
    if (w_ld_ok) begin
      case (ld_sel)
        SEL_PERIOD: w_pend_vld_nxt[IDX_PERIOD] = 1'b1;
        SEL_START:  w_pend_vld_nxt[IDX_START]  = 1'b1;
        SEL_END:    w_pend_vld_nxt[IDX_END]    = 1'b1;
        default:    w_pend_vld_nxt = w_pend_vld_nxt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_period      <= RST_PERIOD;
      r_start       <= '0;
      r_end         <= '0;
      r_pend_period <= '0;
      r_pend_start  <= '0;
      r_pend_end    <= '0;
      r_pend_vld    <= 3'b000;
    end else begin
      r_period   <= w_period_nxt;
      r_start    <= w_start_nxt;
      r_end      <= w_end_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      if (w_ld_ok) begin
        case (ld_sel)
          SEL_PERIOD: r_pend_period <= ld_data;
          SEL_START:  r_pend_start  <= ld_data;
          SEL_END:    r_pend_end    <= ld_data;
          default:    r_pend_period <= r_pend_period;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_wrap      <= 1'b0;
      r_win       <= 1'b0;
      r_match_st  <= 1'b0;
      r_match_end <= 1'b0;
      r_ld_ack    <= 1'b0;
    end else begin
      r_wrap      <= w_term;
      r_win       <= w_active_nxt && !w_nxt_lt_start && w_nxt_lt_end;
      r_match_st  <= w_active_nxt && w_nxt_eq_start;
      r_match_end <= w_active_nxt && w_nxt_eq_end;
      r_ld_ack    <= w_ld_ok;
    end
  end

  assign count     = r_count;
  assign wrap      = r_wrap;
  assign win       = r_win;
  assign match_st  = r_match_st;
  assign match_end = r_match_end;
  assign ld_ack    = r_ld_ack;

`ifdef CTR12_IRQ_EN
  logic r_irq;

  // A new wrap takes priority over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_irq <= 1'b0;
    end else if (w_term) begin
      r_irq <= 1'b1;
    end else if (irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_irq_ack;

  assign w_unused_irq_ack = irq_ack;
  assign irq              = 1'b0;
`endif

endmodule
`default_nettype wire
